// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply/divide unit: op encodings,
// FSM states and the iteration count.
package mips_pkg;

  localparam int unsigned MDU_ITERS = 32;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } mdu_state_e;

endpackage

// File: rtl/mdu_divider_step.sv
// One restoring-divide iteration: shift remainder/quotient left, trial subtract,
// keep the difference and set the quotient bit when the divisor fits.
module mdu_divider_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dsr_i};
  // When ge the true difference is below the divisor, so the low bits suffice.
  assign diff    = shifted[WIDTH-1:0] - dsr_i;
  assign rem_o   = ge ? diff : shifted[WIDTH-1:0];
  assign quo_o   = {quo_i[WIDTH-2:0], ge};

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers, fixed 34-cycle latency.
// Divide support is built only when MUL_DIV_UNIT_DIV_EN is defined.
module mul_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned     CntW    = $clog2(MDU_ITERS);
  localparam logic [CntW-1:0] CntLast = CntW'(MDU_ITERS - 1);

  mdu_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             neg_q, neg_d, done_q, done_d;

  logic             accept, is_div, op_ok, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, step_hi, step_lo, res_hi, res_lo;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod_fix;

  assign a_neg = op[0] & A[WIDTH-1];
  assign b_neg = op[0] & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  // Shift-add multiply: {acc_hi, acc_lo} starts as {0, multiplier}.
  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  assign prod_fix = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

`ifdef MUL_DIV_UNIT_DIV_EN
  logic             div_q, dz_q, rem_neg_q;
  logic [WIDTH-1:0] div_hi, div_lo;

  assign is_div = op[1];
  assign op_ok  = 1'b1;

  mdu_divider_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_i(acc_hi_q),
    .quo_i(acc_lo_q),
    .dsr_i(opnd_q),
    .rem_o(div_hi),
    .quo_o(div_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= 1'b0;
      dz_q      <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (accept) begin
      div_q     <= is_div;
      dz_q      <= (B == '0);
      rem_neg_q <= a_neg;
    end
  end

  assign step_hi = div_q ? div_hi : mul_sum[WIDTH:1];
  assign step_lo = div_q ? div_lo : {mul_sum[0], acc_lo_q[WIDTH-1:1]};

  // Divide by zero leaves the dividend magnitude in the remainder, so only LO needs forcing.
  always_comb begin
    res_hi = prod_fix[2*WIDTH-1:WIDTH];
    res_lo = prod_fix[WIDTH-1:0];
    if (div_q) begin
      res_lo = dz_q ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
      res_hi = rem_neg_q ? -acc_hi_q : acc_hi_q;
    end
  end
`else
  assign is_div  = 1'b0;
  assign op_ok   = ~op[1];
  assign step_hi = mul_sum[WIDTH:1];
  assign step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
  assign res_hi  = prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo  = prod_fix[WIDTH-1:0];
`endif

  assign accept = start && (state_q == IDLE) && op_ok;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (accept) begin
          state_d  = CALC;
          cnt_d    = '0;
          acc_hi_d = '0;
          acc_lo_d = is_div ? a_mag : b_mag;
          opnd_d   = is_div ? b_mag : a_mag;
          neg_d    = a_neg ^ b_neg;
        end
      end
      CALC: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) state_d = FIN;
      end
      FIN: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, the request to begin an operation.
REQ-005 SHALL have port op, input, 2, the operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have ports A and B, input, 32 each: A is the multiplicand or dividend; B is the multiplier or divisor.
REQ-007 SHALL have ports hi_we and lo_we, input, 1 each: MTHI and MTLO write enables.
REQ-008 SHALL have port wdata, input, 32, the MTHI/MTLO write data.
REQ-009 SHALL have port busy, output, 1: high while an operation is in progress.
REQ-010 SHALL have port done, output, 1: a one-cycle pulse when a new result is visible.
REQ-011 SHALL have ports HI and LO, output, 32 each: the registered result, which feeds the writeback 4:1 select mux data inputs.

Function
REQ-012 SHALL use the FSM states IDLE, CALC and FIN; reset enters IDLE.
REQ-013 SHALL accept start only in IDLE, latching op, A and B and going to CALC.
REQ-014 SHALL ignore start in CALC or FIN, with no effect on the operation in flight.
REQ-015 SHALL run CALC for exactly 32 cycles, one radix-2 iteration per cycle; the counter wraps 31->0 and goes to FIN.
REQ-016 SHALL apply the sign fix and write HI/LO on the FIN->IDLE edge.
REQ-017 SHALL have fixed latency for every op: start sampled at edge k; busy high in cycles k+1..k+33; done high only in cycle k+34, the first cycle with new HI/LO.
REQ-018 SHALL produce MULT/MULTU results as {HI,LO} = full 64-bit product; signed for MULT, unsigned for MULTU.
REQ-019 SHALL handle MULT/DIV operands by converting them to magnitudes at acceptance and negating the result in FIN when required.
REQ-020 SHALL produce DIV/DIVU results as LO = quotient and HI = remainder; signed quotient truncates toward zero, and signed remainder takes the sign of the dividend.
REQ-021 SHALL, on divide by zero (B=0, DIV or DIVU), complete in the normal latency with LO=0xFFFFFFFF and HI=A.
REQ-022 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, give LO=0x80000000 and HI=0.
REQ-023 SHALL, in IDLE, load HI from wdata on hi_we and LO from wdata on lo_we at the next edge.
REQ-024 SHALL ignore hi_we/lo_we in CALC and FIN.
REQ-025 SHALL, when start and hi_we/lo_we occur together in IDLE, apply both; the later result overwrites HI/LO.
REQ-026 SHALL hold HI and LO stable except at the FIN->IDLE edge or a permitted MTHI/MTLO write.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force: state=IDLE, counter=0, busy=0, done=0, HI=0, LO=0, and internal operand/remainder registers to 0.
REQ-028 SHALL, on reset mid-operation, abort it with no done pulse; start is first accepted at the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL, with macro MUL_DIV_UNIT_DIV_EN defined, implement DIV/DIVU as specified above.
REQ-030 SHALL, without MUL_DIV_UNIT_DIV_EN, include no divider logic; start with op 10/11 is ignored (stays IDLE, no busy, no done, HI/LO unchanged) and multiply behaviour is unchanged.

Structure
REQ-031 SHALL take the op encodings (MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV), the FSM state enum and the iteration count constant (32) from shared package mips_pkg.
REQ-032 SHALL place the restoring-divide datapath in sub-module mdu_divider_step (one iteration: shift, trial subtract, quotient bit), instantiated only under MUL_DIV_UNIT_DIV_EN.
REQ-033 SHALL keep the multiply path, FSM, counter, sign fix and HI/LO registers in mul_div_unit.

Verification
REQ-034 SHALL cover MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> done at k+34 with HI=0xFFFFFFFE, LO=0x00000001, and busy high for exactly 33 cycles.
REQ-035 SHALL cover MULT A=0xFFFFFFFD (-3) B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-036 SHALL cover DIV A=0xFFFFFFF9 (-7) B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; and DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-037 SHALL cover DIVU A=100 B=0 -> LO=0xFFFFFFFF, HI=0x00000064, done at k+34.
REQ-038 SHALL cover start MULTU 3*5 followed by start DIVU 9/3 and hi_we (wdata=0x1234) at k+5 -> second start and write ignored; HI=0, LO=15, a single done pulse.
REQ-039 SHALL cover rst_n low at k+10 of a MULT -> busy=0, HI=LO=0 immediately, no done; a new MULTU 2*3 afterwards gives LO=6 at the normal latency.
